// File: rtl/uart_pkg.sv
// Shared UART types and helpers for the TX block and the future RX block.
package uart_pkg;

  localparam int UART_DATAW = 8;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } uart_tx_state_e;

  // A baud divisor of 0 would stall the bit timer, so it is treated as 1.
  function automatic logic [31:0] uart_eff_div(input logic [31:0] div);
    return (div == 32'd0) ? 32'd1 : div;
  endfunction

endpackage

// File: rtl/uart_tx_if.sv
// FIFO read-side handshake between the TX byte FIFO (master) and its reader (slave).
interface uart_tx_if
  import uart_pkg::*;
#(
  parameter int DATAW = UART_DATAW
);

  logic [DATAW-1:0] fifo_dat;
  logic             fifo_empty;
  logic             fifo_deq;

  modport master (
    output fifo_dat,
    output fifo_empty,
    input  fifo_deq
  );

  modport slave (
    input  fifo_dat,
    input  fifo_empty,
    output fifo_deq
  );

endinterface

// File: rtl/uart_baud_cnt.sv
// Loadable bit-period down-counter; bit_end_o marks the last cycle of a bit.
module uart_baud_cnt
  import uart_pkg::*;
#(
  parameter int DIVW = 16
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            load_i,
  input  logic [DIVW-1:0] load_val_i,
  output logic            bit_end_o
);

  logic [DIVW-1:0] cnt_q, cnt_d;

  // Load wins over counting; the counter parks at zero when not reloaded.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - DIVW'(1);
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign bit_end_o = (cnt_q == '0);

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter draining a byte FIFO, one pop per frame.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | line high, waiting for tx_en_i and a non-empty FIFO
// START | start bit (line low) for one bit period
// DATA  | data bits, LSB first, one bit period each
// STOP  | stop bit (line high); may chain straight into the next START
module uart_tx
  import uart_pkg::*;
#(
  parameter int DATAW = UART_DATAW,
  parameter int DIVW  = 16
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  uart_tx_if.slave        fifo,
  input  logic [DIVW-1:0] baud_div_i,
  input  logic            tx_en_i,
  output logic            tx_o,
  output logic            busy_o
);

  localparam int BCW = (DATAW > 1) ? $clog2(DATAW) : 1;

  uart_tx_state_e   state_q;
  logic             tx_q;
  logic             busy_q;
  logic [DATAW-1:0] shift_q;
  logic [BCW-1:0]   bit_cnt_q;
  logic [DIVW-1:0]  div_q;

  logic             bit_end;
  logic             launch_slot;
  logic             launch;
  logic [DIVW-1:0]  div_eff;
  logic             cnt_load;
  logic [DIVW-1:0]  cnt_val;

  assign div_eff = DIVW'(uart_eff_div(32'(baud_div_i)));

  // A new frame may start from IDLE, or back-to-back on the final stop-bit cycle.
  // Gating with rst_ni keeps the FIFO from being popped while the FSM is held in reset.
  always_comb begin
    launch_slot = (state_q == IDLE) || ((state_q == STOP) && bit_end);
    launch      = rst_ni && tx_en_i && !fifo.fifo_empty && launch_slot;
  end

  assign fifo.fifo_deq = launch;

  // Reload the bit timer on launch and at the end of every bit that has a successor.
  always_comb begin
    cnt_load = launch || (bit_end && ((state_q == START) || (state_q == DATA)));
    cnt_val  = launch ? (div_eff - DIVW'(1)) : (div_q - DIVW'(1));
  end

  uart_baud_cnt #(
    .DIVW(DIVW)
  ) u_baud_cnt (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .load_i    (cnt_load),
    .load_val_i(cnt_val),
    .bit_end_o (bit_end)
  );

  // Frame FSM with registered line and busy outputs.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      div_q     <= '0;
    end else if (launch) begin
      shift_q   <= fifo.fifo_dat;
      div_q     <= div_eff;
      bit_cnt_q <= '0;
      state_q   <= START;
      tx_q      <= 1'b0;
      busy_q    <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          tx_q   <= 1'b1;
          busy_q <= 1'b0;
        end
        START: begin
          if (bit_end) begin
            state_q <= DATA;
            tx_q    <= shift_q[0];
          end
        end
        DATA: begin
          if (bit_end) begin
            shift_q   <= shift_q >> 1;
            bit_cnt_q <= bit_cnt_q + BCW'(1);
            if (bit_cnt_q == BCW'(DATAW - 1)) begin
              state_q <= STOP;
              tx_q    <= 1'b1;
            end else begin
              tx_q <= shift_q[1];
            end
          end
        end
        STOP: begin
          if (bit_end) begin
            state_q <= IDLE;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          tx_q    <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign tx_o   = tx_q;
  assign busy_o = busy_q;

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx: expected frames are queued at stimulus time and
// a line monitor pops and checks each frame as it appears on tx_o.
module tb_uart_tx;
  import uart_pkg::*;

  typedef struct {
    logic [7:0] data;
    int         div;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_ni = 1'b0;
  logic [15:0] baud_div = 16'd4;
  logic        tx_en = 1'b0;
  logic        tx_o;
  logic        busy_o;

  int errors = 0;
  int checks = 0;

  exp_t exp_q[$];

  logic [7:0] mem [16];
  int wr_ptr = 0;
  int rd_ptr = 0;
  int cyc = 0;
  int deq_count = 0;
  int deq_last = 0;
  int deq_prev = 0;
  int busy_cycles = 0;

  always #5 clk = ~clk;

  uart_tx_if #(.DATAW(8)) fifo_if ();

  assign fifo_if.fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_if.fifo_dat   = mem[rd_ptr[3:0]];

  uart_tx #(
    .DATAW(8),
    .DIVW (16)
  ) dut (
    .clk_i     (clk),
    .rst_ni    (rst_ni),
    .fifo      (fifo_if.slave),
    .baud_div_i(baud_div),
    .tx_en_i   (tx_en),
    .tx_o      (tx_o),
    .busy_o    (busy_o)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Bench-side FIFO model: tail advances on the edge that sees the dequeue strobe.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (fifo_if.fifo_deq === 1'b1) begin
      chk("deq_not_empty", {31'd0, fifo_if.fifo_empty}, 32'd0);
      rd_ptr    <= rd_ptr + 1;
      deq_count <= deq_count + 1;
      deq_prev  <= deq_last;
      deq_last  <= cyc;
    end
  end

  always @(negedge clk) begin
    if (busy_o === 1'b1) busy_cycles <= busy_cycles + 1;
  end

  // Line monitor: a falling edge on tx_o starts a frame; each bit must hold for div cycles.
  initial begin : monitor
    logic prev_tx;
    logic aborted;
    logic ok;
    logic [9:0] bits;
    exp_t e;
    prev_tx = 1'b1;
    forever begin
      @(negedge clk);
      if (rst_ni && prev_tx && (tx_o === 1'b0)) begin
        chk("frame_expected", {31'd0, (exp_q.size() != 0)}, 32'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          bits = {1'b1, e.data, 1'b0};
          aborted = 1'b0;
          for (int b = 0; b < 10; b++) begin
            ok = 1'b1;
            for (int c = 0; c < e.div; c++) begin
              if (!aborted) begin
                if ((b != 0) || (c != 0)) @(negedge clk);
                if (!rst_ni) aborted = 1'b1;
                else if ((tx_o !== bits[b]) || (busy_o !== 1'b1)) ok = 1'b0;
              end
            end
            if (!aborted) chk($sformatf("frame_%02h_bit%0d", e.data, b), {31'd0, ok}, 32'd1);
          end
        end
      end
      prev_tx = tx_o;
    end
  end

  task automatic push_byte(input logic [7:0] d);
    mem[wr_ptr[3:0]] = d;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic expect_frame(input logic [7:0] d, input int div);
    exp_t e;
    e.data = d;
    e.div  = div;
    exp_q.push_back(e);
  endtask

  task automatic drv_step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_busy(input logic level, input int budget, input string name);
    int n;
    n = 0;
    @(negedge clk);
    while ((busy_o !== level) && (n < budget)) begin
      @(negedge clk);
      n++;
    end
    chk(name, {31'd0, busy_o}, {31'd0, level});
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int d0;
    int b0;

    // Reset with an empty FIFO and transmit enabled.
    rst_ni = 1'b0;
    tx_en  = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_tx", {31'd0, tx_o}, 32'd1);
    chk("rst_busy", {31'd0, busy_o}, 32'd0);
    chk("rst_deq", {31'd0, fifo_if.fifo_deq}, 32'd0);
    drv_step();
    rst_ni = 1'b1;
    repeat (100) @(negedge clk);
    chk("empty_tx", {31'd0, tx_o}, 32'd1);
    chk("empty_busy_cycles", busy_cycles, 0);
    chk("empty_deq_count", deq_count, 0);

    // Single byte 0xA5, div=4.
    drv_step();
    baud_div = 16'd4;
    d0 = deq_count;
    b0 = busy_cycles;
    expect_frame(8'hA5, 4);
    push_byte(8'hA5);
    wait_busy(1'b1, 10, "a5_busy_rise");
    wait_busy(1'b0, 60, "a5_busy_fall");
    chk("a5_deq_count", deq_count - d0, 1);
    chk("a5_busy_cycles", busy_cycles - b0, 40);

    // Back-to-back 0x00 and 0xFF, div=3.
    drv_step();
    baud_div = 16'd3;
    d0 = deq_count;
    b0 = busy_cycles;
    expect_frame(8'h00, 3);
    expect_frame(8'hFF, 3);
    push_byte(8'h00);
    push_byte(8'hFF);
    wait_busy(1'b1, 10, "b2b_busy_rise");
    wait_busy(1'b0, 100, "b2b_busy_fall");
    chk("b2b_deq_count", deq_count - d0, 2);
    chk("b2b_deq_spacing", deq_last - deq_prev, 30);
    chk("b2b_busy_cycles", busy_cycles - b0, 60);

    // Divisor 0 behaves as 1 cycle per bit.
    drv_step();
    baud_div = 16'd0;
    d0 = deq_count;
    b0 = busy_cycles;
    expect_frame(8'h81, 1);
    push_byte(8'h81);
    wait_busy(1'b1, 10, "div0_busy_rise");
    wait_busy(1'b0, 30, "div0_busy_fall");
    chk("div0_deq_count", deq_count - d0, 1);
    chk("div0_busy_cycles", busy_cycles - b0, 10);

    // tx_en dropped mid-frame: current byte finishes, next stays queued.
    drv_step();
    baud_div = 16'd4;
    d0 = deq_count;
    expect_frame(8'h3C, 4);
    push_byte(8'h3C);
    push_byte(8'h55);
    wait_busy(1'b1, 10, "en_busy_rise");
    repeat (12) @(posedge clk);
    #1;
    tx_en = 1'b0;
    wait_busy(1'b0, 60, "en_busy_fall");
    chk("en_deq_first", deq_count - d0, 1);
    repeat (20) @(negedge clk);
    chk("en_deq_held", deq_count - d0, 1);
    chk("en_idle_tx", {31'd0, tx_o}, 32'd1);
    chk("en_idle_busy", {31'd0, busy_o}, 32'd0);
    expect_frame(8'h55, 4);
    drv_step();
    tx_en = 1'b1;
    wait_busy(1'b1, 10, "en2_busy_rise");
    wait_busy(1'b0, 60, "en2_busy_fall");
    chk("en_deq_second", deq_count - d0, 2);

    // Reset pulse during data bit 3 of 0x96, div=8; 0x42 follows normally.
    drv_step();
    baud_div = 16'd8;
    d0 = deq_count;
    expect_frame(8'h96, 8);
    expect_frame(8'h42, 8);
    push_byte(8'h96);
    push_byte(8'h42);
    wait_busy(1'b1, 10, "rst_busy_rise");
    repeat (34) @(posedge clk);
    #1;
    rst_ni = 1'b0;
    @(posedge clk);
    #1;
    rst_ni = 1'b1;
    @(negedge clk);
    chk("abort_tx", {31'd0, tx_o}, 32'd1);
    chk("abort_busy", {31'd0, busy_o}, 32'd0);
    chk("abort_deq_count", deq_count - d0, 1);
    wait_busy(1'b1, 10, "post_rst_busy_rise");
    wait_busy(1'b0, 120, "post_rst_busy_fall");
    chk("post_rst_deq_count", deq_count - d0, 2);

    repeat (10) @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);
    chk("final_tx", {31'd0, tx_o}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
